// File: rtl/rslt_bram_writer.sv
// Collects one AXI-Stream result frame and writes each beat to consecutive BRAM addresses.
// A run is framed by base and size captured at start; a tlast that disagrees with size ends in ERR.
module rslt_bram_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  operation_start,
    input  logic [ADDR_WIDTH-1:0] rslt_base,
    input  logic [ADDR_WIDTH-1:0] rslt_size,
    input  logic [DATA_WIDTH-1:0] s_axis_rslt_tdata,
    input  logic                  s_axis_rslt_tvalid,
    output logic                  s_axis_rslt_tready,
    input  logic                  s_axis_rslt_tlast,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wrdata,
    output logic                  operation_in_progress,
    output logic                  operation_complete,
    output logic                  operation_error,
    output logic [ADDR_WIDTH-1:0] words_written
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] size_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic                  accept;
    logic                  last_beat;

    // tready depends only on the registered state, so there is no path from tvalid.
    assign s_axis_rslt_tready    = (state == RUN);
    assign accept                = s_axis_rslt_tvalid && (state == RUN);
    assign last_beat             = (count_q == size_q - ADDR_WIDTH'(1));

    assign operation_in_progress = (state == RUN);
    assign operation_complete    = (state == DONE);
    assign operation_error       = (state == ERR);
    assign words_written         = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (operation_start) begin
                    state_next = (rslt_size == '0) ? ERR : RUN;
                end
            end
            RUN: begin
                // The beat that ends the run is still written, whichever way it ends.
                if (accept) begin
                    if (last_beat) begin
                        state_next = s_axis_rslt_tlast ? DONE : ERR;
                    end else if (s_axis_rslt_tlast) begin
                        state_next = ERR;
                    end
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            size_q      <= '0;
            count_q     <= '0;
            bram_en     <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_wrdata <= '0;
        end else begin
            bram_en <= accept;
            bram_we <= accept;
            if (state == IDLE && operation_start) begin
                base_q  <= rslt_base;
                size_q  <= rslt_size;
                count_q <= '0;
            end
            // Address arithmetic wraps naturally at the port width.
            if (accept) begin
                bram_addr   <= base_q + count_q;
                bram_wrdata <= s_axis_rslt_tdata;
                count_q     <= count_q + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rslt_bram_writer.sv
// Randomized scoreboard bench for rslt_bram_writer: the driver predicts BRAM writes and run
// outcomes from the frame rules, and a negedge monitor pops and compares every write it sees.
module tb_rslt_bram_writer;

    localparam int DW = 16;
    localparam int AW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          operation_start;
    logic [AW-1:0] rslt_base;
    logic [AW-1:0] rslt_size;
    logic [DW-1:0] s_axis_rslt_tdata;
    logic          s_axis_rslt_tvalid;
    logic          s_axis_rslt_tready;
    logic          s_axis_rslt_tlast;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wrdata;
    logic          operation_in_progress;
    logic          operation_complete;
    logic          operation_error;
    logic [AW-1:0] words_written;

    int            tests_run    = 0;
    int            tests_failed = 0;
    int            cyc          = 0;
    logic          rst_at_edge  = 1'b0;
    int            complete_cnt = 0;
    int            error_cnt    = 0;
    logic [AW-1:0] last_addr    = '0;
    logic [DW-1:0] last_data    = '0;
    exp_t          exp_q[$];

    rslt_bram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .operation_start       (operation_start),
        .rslt_base             (rslt_base),
        .rslt_size             (rslt_size),
        .s_axis_rslt_tdata     (s_axis_rslt_tdata),
        .s_axis_rslt_tvalid    (s_axis_rslt_tvalid),
        .s_axis_rslt_tready    (s_axis_rslt_tready),
        .s_axis_rslt_tlast     (s_axis_rslt_tlast),
        .bram_en               (bram_en),
        .bram_we               (bram_we),
        .bram_addr             (bram_addr),
        .bram_wrdata           (bram_wrdata),
        .operation_in_progress (operation_in_progress),
        .operation_complete    (operation_complete),
        .operation_error       (operation_error),
        .words_written         (words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_at_edge = rst;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every cycle after an edge, match BRAM activity against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (operation_complete) complete_cnt++;
        if (operation_error) error_cnt++;
        checkOutput("we_follows_en", bram_we, bram_en);
        if (rst_at_edge) begin
            checkOutput("rst_bram_en", bram_en, 0);
            checkOutput("rst_bram_addr", bram_addr, 0);
            checkOutput("rst_bram_wrdata", bram_wrdata, 0);
            checkOutput("rst_tready", s_axis_rslt_tready, 0);
            checkOutput("rst_in_progress", operation_in_progress, 0);
            checkOutput("rst_complete", operation_complete, 0);
            checkOutput("rst_error", operation_error, 0);
            checkOutput("rst_words_written", words_written, 0);
            last_addr = '0;
            last_data = '0;
        end else if (bram_en) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_addr", bram_addr, e.addr);
                checkOutput("write_data", bram_wrdata, e.data);
                checkOutput("write_cycle", cyc, e.cyc);
            end
            last_addr = bram_addr;
            last_data = bram_wrdata;
        end else begin
            checkOutput("hold_addr", bram_addr, last_addr);
            checkOutput("hold_data", bram_wrdata, last_data);
        end
    end

    // One run: gap_mode 0 = always valid, 1 = alternate, 2 = random; tlast_at/reset_after = -1 for none.
    task automatic applyStimulus(input logic [AW-1:0] base, input int size, input int tlast_at,
                                 input int gap_mode, input bit rand_data, input int reset_after);
        int            accepted = 0;
        int            tick     = 0;
        bit            ended;
        bit            do_reset = 0;
        bit            vld;
        bit            lst;
        bit            exp_done;
        bit            exp_err;
        int            exp_words;
        int            c0_cmpl  = complete_cnt;
        int            c0_err   = error_cnt;
        logic [DW-1:0] data;
        exp_t          e;

        @(negedge clk);
        operation_start    = 1'b1;
        rslt_base          = base;
        rslt_size          = AW'(size);
        s_axis_rslt_tvalid = 1'b0;
        @(negedge clk);
        rslt_base = AW'($urandom);
        rslt_size = AW'($urandom);
        operation_start = 1'b0;
        ended = (size == 0);

        while (!ended && tick < 200) begin
            checkOutput("in_progress_during_run", operation_in_progress, 1);
            checkOutput("tready_during_run", s_axis_rslt_tready, 1);
            case (gap_mode)
                0:       vld = 1'b1;
                1:       vld = (tick % 2 == 0);
                default: vld = ($urandom_range(0, 2) != 0);
            endcase
            if (vld && s_axis_rslt_tready) begin
                data = rand_data ? DW'($urandom) : DW'(16'hA0 + accepted);
                lst  = (accepted == tlast_at);
                s_axis_rslt_tvalid = 1'b1;
                s_axis_rslt_tdata  = data;
                s_axis_rslt_tlast  = lst;
                e.addr = AW'((int'(base) + accepted) % 65536);
                e.data = data;
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
                accepted++;
                if (accepted == size || lst) ended = 1;
                else if (accepted - 1 == reset_after) begin
                    do_reset = 1;
                    ended    = 1;
                end
            end else begin
                s_axis_rslt_tvalid = 1'b0;
                s_axis_rslt_tdata  = DW'($urandom);
                s_axis_rslt_tlast  = 1'($urandom);
            end
            operation_start = 1'($urandom);
            tick++;
            @(negedge clk);
        end
        if (!ended) checkOutput("run_timeout", 0, 1);

        if (do_reset) begin
            rst                = 1'b1;
            operation_start    = 1'b0;
            s_axis_rslt_tvalid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
        end

        // Aftermath: start in DONE/ERR must be ignored, valid without ready must do nothing.
        for (int i = 0; i < 4; i++) begin
            checkOutput("tready_after_run", s_axis_rslt_tready, 0);
            checkOutput("in_progress_after_run", operation_in_progress, 0);
            operation_start    = (i == 0) && !do_reset;
            s_axis_rslt_tvalid = 1'($urandom);
            s_axis_rslt_tdata  = DW'($urandom);
            s_axis_rslt_tlast  = 1'($urandom);
            @(negedge clk);
        end
        operation_start    = 1'b0;
        s_axis_rslt_tvalid = 1'b0;

        if (do_reset) begin
            exp_done = 0; exp_err = 0; exp_words = 0;
        end else if (size == 0) begin
            exp_done = 0; exp_err = 1; exp_words = 0;
        end else begin
            exp_done  = (accepted == size) && (tlast_at == accepted - 1);
            exp_err   = !exp_done;
            exp_words = accepted;
        end
        checkOutput("complete_pulses", complete_cnt - c0_cmpl, exp_done);
        checkOutput("error_pulses", error_cnt - c0_err, exp_err);
        checkOutput("words_written", words_written, exp_words);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int sz;
        int tl;
        int ra;
        rst                = 1'b1;
        operation_start    = 1'b0;
        rslt_base          = '0;
        rslt_size          = '0;
        s_axis_rslt_tdata  = '0;
        s_axis_rslt_tvalid = 1'b0;
        s_axis_rslt_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus(16'h0010, 4, 3, 0, 0, -1);
        applyStimulus(16'h0010, 4, 3, 1, 0, -1);
        applyStimulus(16'h0010, 4, 1, 0, 0, -1);
        applyStimulus(16'h0020, 3, -1, 0, 0, -1);
        applyStimulus(16'h0030, 0, -1, 0, 0, -1);
        applyStimulus(16'hFFFE, 4, 3, 0, 0, -1);
        applyStimulus(16'hFFFE, 4, 3, 0, 0, 1);
        applyStimulus(16'h0100, 4, 3, 2, 1, -1);

        for (int n = 0; n < 30; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            case ($urandom_range(0, 3))
                0, 1:    tl = sz - 1;
                2:       tl = (sz > 0) ? int'($urandom_range(0, sz - 1)) : -1;
                default: tl = -1;
            endcase
            ra = ($urandom_range(0, 5) == 0 && sz > 1) ? int'($urandom_range(0, sz - 2)) : -1;
            applyStimulus(AW'($urandom), sz, tl, 2, 1, ra);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
